// File: rtl/if_id_latch.sv
// IF/ID pipeline register for the 16-bit WISC core: holds the fetched instruction and PC+2,
// and pre-decodes immediate extension controls. Optional IFID_BUBBLE_CNT_EN adds a saturating bubble counter.
module if_id_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_inc_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc_inc_out,
  output logic        valid_out,
  output logic [10:0] imm_11,
  output logic [7:0]  imm_8,
  output logic [4:0]  imm_5,
  output logic        ext_type,
  output logic [1:0]  ext_len
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  localparam logic [15:0] NOP       = 16'h0800;
  localparam logic [1:0]  LEN_5     = 2'b00;
  localparam logic [1:0]  LEN_8     = 2'b01;
  localparam logic [1:0]  LEN_11    = 2'b10;
  localparam logic        EXT_SIGN  = 1'b1;
  localparam logic        EXT_ZERO  = 1'b0;

  logic [15:0] instr_q;
  logic [15:0] pc_q;
  logic        valid_q;
  logic        ext_type_q;
  logic [1:0]  ext_len_q;

  logic [15:0] load_instr;
  logic        dec_type;
  logic [1:0]  dec_len;

  // Decode is done on the value about to be loaded, so a bubble load decodes the NOP.
  always_comb begin
    load_instr = fetch_valid ? instr_in : NOP;
    dec_type   = EXT_SIGN;
    dec_len    = LEN_5;
    casez (load_instr[15:11])
      5'b001?0: begin dec_len = LEN_11; dec_type = EXT_SIGN; end
      5'b001?1,
      5'b011??,
      5'b11000: begin dec_len = LEN_8;  dec_type = EXT_SIGN; end
      5'b10010: begin dec_len = LEN_8;  dec_type = EXT_ZERO; end
      5'b0101?,
      5'b101??: begin dec_len = LEN_5;  dec_type = EXT_ZERO; end
      default:  begin dec_len = LEN_5;  dec_type = EXT_SIGN; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP;
      pc_q       <= 16'h0000;
      valid_q    <= 1'b0;
      ext_type_q <= EXT_SIGN;
      ext_len_q  <= LEN_5;
    end else if (flush) begin
      instr_q    <= NOP;
      pc_q       <= 16'h0000;
      valid_q    <= 1'b0;
      ext_type_q <= EXT_SIGN;
      ext_len_q  <= LEN_5;
    end else if (!stall) begin
      instr_q    <= load_instr;
      pc_q       <= pc_inc_in;
      valid_q    <= fetch_valid;
      ext_type_q <= dec_type;
      ext_len_q  <= dec_len;
    end
  end

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;
  logic        bubble_event;

  // A bubble enters the stage on a flush or on an unstalled load without a valid fetch.
  assign bubble_event = flush | (~stall & ~fetch_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 16'h0000;
    end else if (bubble_event && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign instr_out  = instr_q;
  assign pc_inc_out = pc_q;
  assign valid_out  = valid_q;
  assign ext_type   = ext_type_q;
  assign ext_len    = ext_len_q;
  assign imm_11     = instr_q[10:0];
  assign imm_8      = instr_q[7:0];
  assign imm_5      = instr_q[4:0];

endmodule
